// File: rtl/rom_loader_pkg.sv
// Shared constants for the boot-time ROM loader: FSM state encodings and the
// default instruction-ROM word-address width.
package rom_loader_pkg;

   localparam int ROM_ADDR_WIDTH = 17;

   typedef logic [2:0] ld_state_t;

   localparam ld_state_t ROM_LD_CNT_HI = 3'd0;
   localparam ld_state_t ROM_LD_CNT_LO = 3'd1;
   localparam ld_state_t ROM_LD_DATA   = 3'd2;
   localparam ld_state_t ROM_LD_CSUM   = 3'd3;
   localparam ld_state_t ROM_LD_DONE   = 3'd4;
   localparam ld_state_t ROM_LD_ERROR  = 3'd5;

   // States in which the loader still consumes stream bytes.
   function automatic logic is_loading(input ld_state_t st);
      return (st == ROM_LD_CNT_HI) || (st == ROM_LD_CNT_LO) ||
             (st == ROM_LD_DATA)   || (st == ROM_LD_CSUM);
   endfunction

endpackage

// File: rtl/rom_word_assembler.sv
// Packs instruction bytes MSB-first into 32-bit words and keeps the running
// XOR of every byte it has taken in.
module rom_word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        word_ready,
   output logic [31:0] word,
   output logic [7:0]  csum
);

   logic [23:0] shift_q;
   logic [1:0]  cnt_q;
   logic [7:0]  csum_q;

   // NOTE: the shift register is reset along with the counter so a word
   // abandoned by a mid-load reset can never leak into the next image.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
      end else if (byte_en) begin
         shift_q <= {shift_q[15:0], byte_data};
         cnt_q   <= cnt_q + 2'd1;
         csum_q  <= csum_q ^ byte_data;
      end
   end

   // The fourth byte completes the word in the same cycle it is accepted.
   assign word_ready = byte_en && (cnt_q == 2'd3);
   assign word       = {shift_q, byte_data};
   assign csum       = csum_q;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: streams a counted, checksummed image into the instruction ROM
// and holds the core in reset until the image is known good.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = ROM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   output logic                  byte_ready_o,
   output logic                  rom_we_o,
   output logic [ADDR_WIDTH-1:0] rom_waddr_o,
   output logic [31:0]           rom_wdata_o,
   output logic                  cpu_rst_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

   ld_state_t             state_q;
   logic [7:0]            cnt_hi_q;
   logic [15:0]           n_words_q;
   logic [ADDR_WIDTH:0]   word_idx_q;
   logic [ADDR_WIDTH:0]   idx_inc;
   logic [15:0]           count_n;
   logic                  accept;
   logic                  asm_en;
   logic                  word_ready;
   logic [31:0]           word;
   logic [7:0]            csum;

   // NOTE: ready is a function of state only; looking at byte_valid_i here
   // would create a combinational valid->ready loop with the upstream source.
   assign byte_ready_o = !rst && is_loading(state_q);
   assign accept       = byte_valid_i && byte_ready_o;
   assign asm_en       = accept && (state_q == ROM_LD_DATA);
   assign count_n      = {cnt_hi_q, byte_data_i};
   assign idx_inc      = word_idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

   rom_word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .byte_en    (asm_en),
      .byte_data  (byte_data_i),
      .word_ready (word_ready),
      .word       (word),
      .csum       (csum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ROM_LD_CNT_HI;
         cnt_hi_q    <= '0;
         n_words_q   <= '0;
         word_idx_q  <= '0;
         rom_we_o    <= 1'b0;
         rom_waddr_o <= '0;
         rom_wdata_o <= '0;
         cpu_rst_o   <= 1'b1;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         rom_we_o <= 1'b0;
         if (accept) begin
            case (state_q)
               ROM_LD_CNT_HI: begin
                  cnt_hi_q <= byte_data_i;
                  state_q  <= ROM_LD_CNT_LO;
               end
               ROM_LD_CNT_LO: begin
                  n_words_q <= count_n;
                  if ({16'b0, count_n} > CAPACITY) begin
                     state_q <= ROM_LD_ERROR;
                     err_o   <= 1'b1;
                  end else if (count_n == 16'd0) begin
                     state_q <= ROM_LD_CSUM;
                  end else begin
                     state_q <= ROM_LD_DATA;
                  end
               end
               ROM_LD_DATA: begin
                  if (word_ready) begin
                     rom_we_o    <= 1'b1;
                     rom_waddr_o <= word_idx_q[ADDR_WIDTH-1:0];
                     rom_wdata_o <= word;
                     word_idx_q  <= idx_inc;
                     if (32'(idx_inc) == 32'(n_words_q)) state_q <= ROM_LD_CSUM;
                  end
               end
               ROM_LD_CSUM: begin
                  if (byte_data_i == csum) begin
                     state_q   <= ROM_LD_DONE;
                     cpu_rst_o <= 1'b0;
                     done_o    <= 1'b1;
                  end else begin
                     state_q <= ROM_LD_ERROR;
                     err_o   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven image loads on a full-size
// and a 16-word instance, plus a reset-in-the-middle-of-a-word sequence.
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid [2];
   logic [7:0]  data  [2];
   logic        rdy   [2];
   logic        we    [2];
   logic [31:0] wdata [2];
   logic        cpu_rst [2];
   logic        done  [2];
   logic        err   [2];
   logic [16:0] waddr0;
   logic [3:0]  waddr1;

   always #5 clk = ~clk;

   rom_loader dut0 (
      .clk(clk), .rst(rst), .byte_valid_i(valid[0]), .byte_data_i(data[0]),
      .byte_ready_o(rdy[0]), .rom_we_o(we[0]), .rom_waddr_o(waddr0),
      .rom_wdata_o(wdata[0]), .cpu_rst_o(cpu_rst[0]), .done_o(done[0]), .err_o(err[0])
   );

   rom_loader #(.ADDR_WIDTH(4)) dut1 (
      .clk(clk), .rst(rst), .byte_valid_i(valid[1]), .byte_data_i(data[1]),
      .byte_ready_o(rdy[1]), .rom_we_o(we[1]), .rom_waddr_o(waddr1),
      .rom_wdata_o(wdata[1]), .cpu_rst_o(cpu_rst[1]), .done_o(done[1]), .err_o(err[1])
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      int         sel;
      int         n;
      logic [7:0] flip;
      int         gap;
      logic       exp_done;
      logic       exp_err;
      int         exp_writes;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   wr_t         wr0_q[$];
   wr_t         wr1_q[$];
   logic [7:0]  stream[$];
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_acc;
   vec_t        vecs[9];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (we[0] === 1'b1) wr0_q.push_back('{int'(waddr0), wdata[0], cyc});
      if (we[1] === 1'b1) wr1_q.push_back('{int'(waddr1), wdata[1], cyc});
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: expected writes and accepted byte count from the stream format.
   task automatic model(input int aw);
      int         n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      n = int'({stream[0], stream[1]});
      if (n > (1 << aw)) begin
         exp_acc = 2;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
         for (int j = 0; j < 4; j++) x ^= stream[2+4*i+j];
      end
      exp_acc = 3 + 4 * n;
   endtask

   task automatic build(input int n, input logic [7:0] flip);
      logic [31:0] w;
      logic [7:0]  x;
      stream.delete();
      x = 8'h00;
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         w = (i == 0) ? 32'h3401_1100 : (i == 1) ? 32'h3422_0020 : $urandom;
         for (int j = 3; j >= 0; j--) begin
            stream.push_back(w[8*j +: 8]);
            x ^= w[8*j +: 8];
         end
      end
      stream.push_back(x ^ flip);
   endtask

   task automatic do_reset(input int sel);
      @(negedge clk);
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_we",      {63'b0, we[sel]}, 64'd0);
      check("rst_waddr",   (sel == 1) ? {60'b0, waddr1} : {47'b0, waddr0}, 64'd0);
      check("rst_wdata",   {32'b0, wdata[sel]}, 64'd0);
      check("rst_cpu_rst", {63'b0, cpu_rst[sel]}, 64'd1);
      check("rst_done",    {63'b0, done[sel]}, 64'd0);
      check("rst_err",     {63'b0, err[sel]}, 64'd0);
      check("rst_ready",   {63'b0, rdy[sel]}, 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {63'b0, rdy[sel]}, 64'd1);
      wr0_q.delete();
      wr1_q.delete();
   endtask

   // Sends the stream; returns at the negedge after the last accepted byte.
   task automatic send(input int sel, input int gap, output int acc);
      int idx   = 0;
      int guard = 0;
      @(negedge clk);
      forever begin
         if (idx >= stream.size() || rdy[sel] !== 1'b1) begin
            valid[sel] = 1'b0;
            break;
         end
         if (guard++ > 3000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d bytes expected %0d", idx, stream.size());
            break;
         end
         if (gap > 0 && $urandom_range(99) < gap) begin
            valid[sel] = 1'b0;
            data[sel]  = 8'($urandom);
         end else begin
            valid[sel] = 1'b1;
            data[sel]  = stream[idx];
            idx++;
         end
         @(negedge clk);
      end
      acc = idx;
   endtask

   task automatic check_writes(input string tag, input int sel, input int exp_n, input int gap);
      wr_t got[$];
      got = (sel == 1) ? wr1_q : wr0_q;
      check({tag, "_nwrites"}, 64'(got.size()), 64'(exp_n));
      for (int i = 0; i < got.size() && i < exp_addr.size(); i++) begin
         check({tag, "_addr"}, 64'(got[i].addr), 64'(exp_addr[i]));
         check({tag, "_data"}, {32'b0, got[i].data}, {32'b0, exp_data[i]});
         if (gap == 0 && i > 0) check({tag, "_spacing"}, 64'(got[i].cyc - got[i-1].cyc), 64'd4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int nwr;
      rst      = 1'b1;
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      data[0]  = 8'h00;
      data[1]  = 8'h00;

      //            sel  n      flip   gap done  err   writes
      vecs[0] = '{0,   2,     8'h00, 0,  1'b1, 1'b0, 2};
      vecs[1] = '{0,   2,     8'h01, 0,  1'b0, 1'b1, 2};
      vecs[2] = '{0,   0,     8'h00, 0,  1'b1, 1'b0, 0};
      vecs[3] = '{0,   2,     8'h00, 50, 1'b1, 1'b0, 2};
      vecs[4] = '{0,   7,     8'h00, 30, 1'b1, 1'b0, 7};
      vecs[5] = '{0,   5,     8'h80, 0,  1'b0, 1'b1, 5};
      vecs[6] = '{1,   'h11,  8'h00, 0,  1'b0, 1'b1, 0};
      vecs[7] = '{1,   16,    8'h00, 0,  1'b1, 1'b0, 16};
      vecs[8] = '{1,   3,     8'h00, 20, 1'b1, 1'b0, 3};

      for (int v = 0; v < 9; v++) begin
         int sel;
         sel = vecs[v].sel;
         do_reset(sel);
         build(vecs[v].n, vecs[v].flip);
         model(sel == 1 ? 4 : 17);
         send(sel, vecs[v].gap, acc);
         check("accepted", 64'(acc), 64'(exp_acc));
         check("done",     {63'b0, done[sel]}, {63'b0, vecs[v].exp_done});
         check("err",      {63'b0, err[sel]},  {63'b0, vecs[v].exp_err});
         check("cpu_rst",  {63'b0, cpu_rst[sel]}, {63'b0, !vecs[v].exp_done});
         check("ready_end", {63'b0, rdy[sel]}, 64'd0);
         check_writes("vec", sel, vecs[v].exp_writes, vecs[v].gap);
         // Terminal states must ignore further traffic.
         for (int k = 0; k < 6; k++) begin
            valid[sel] = 1'b1;
            data[sel]  = 8'($urandom);
            @(negedge clk);
         end
         valid[sel] = 1'b0;
         nwr = (sel == 1) ? wr1_q.size() : wr0_q.size();
         check("sticky_done",   {63'b0, done[sel]}, {63'b0, vecs[v].exp_done});
         check("sticky_err",    {63'b0, err[sel]},  {63'b0, vecs[v].exp_err});
         check("sticky_ready",  {63'b0, rdy[sel]}, 64'd0);
         check("sticky_writes", 64'(nwr), 64'(vecs[v].exp_writes));
      end

      // Reset after six data bytes: one full word written, half a word pending.
      do_reset(0);
      build(2, 8'h00);
      while (stream.size() > 8) void'(stream.pop_back());
      model(17);
      send(0, 0, acc);
      check("partial_nwrites", 64'(wr0_q.size()), 64'd1);
      check("partial_done",    {63'b0, done[0]}, 64'd0);
      check("partial_ready",   {63'b0, rdy[0]}, 64'd1);
      do_reset(0);
      build(2, 8'h00);
      model(17);
      send(0, 0, acc);
      check("reload_accepted", 64'(acc), 64'(exp_acc));
      check_writes("reload", 0, 2, 0);
      check("reload_done",    {63'b0, done[0]}, 64'd1);
      check("reload_cpu_rst", {63'b0, cpu_rst[0]}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
